// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared definitions for the bit-serial adder: FSM state
//               encoding and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of bits needed to count 0 .. value-1 (minimum 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add32_add_full.sv
`default_nettype none
// ============================================================================
// Module      : add_full
// Description : Purely combinational 1-bit full adder. Port order mirrors the
//               full-subtractor cell (results first, then operands).
// Ports       : sum       - a ^ b ^ carry_in
//               carry_out - majority(a, b, carry_in)
//               a, b      - operand bits
//               carry_in  - incoming carry
// Revision    : 1.0 - initial release
// ============================================================================
module add_full (
  output logic sum,
  output logic carry_out,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule : add_full
`default_nettype wire

// File: rtl/serial_add32.sv
`default_nettype none
// ============================================================================
// Module      : serial_add32
// Description : Bit-serial ripple adder. Adds one bit pair per clock, LSB
//               first, through a single full-adder cell, then presents sum,
//               carry-out and signed overflow with a one-cycle done pulse.
// Ports       : clk, reset (sync, active-high)
//               start, a, b, carry_in  - request and operands
//               busy                   - operation in progress
//               done                   - one-cycle result-valid pulse
//               sum, carry_out         - held result
//               overflow               - signed overflow (held with sum)
// Options     : SERIAL_ADD_OVF_EN - when defined, builds the carry-into-MSB
//               flop and drives overflow; otherwise overflow is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add32
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int             CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_r;
  logic             fa_sum;
  logic             fa_carry;

  add_full u_add_full (
    .sum       (fa_sum),
    .carry_out (fa_carry),
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (carry_r)
  );

`ifdef SERIAL_ADD_OVF_EN
  // Carry into bit WIDTH-1, captured on the final SHIFT cycle.
  logic msb_carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      msb_carry <= 1'b0;
    end else if (state == SHIFT && cnt == CNT_LAST) begin
      msb_carry <= carry_r;
    end
  end

  // Both terms are held registers, so overflow changes only with sum.
  assign overflow = msb_carry ^ carry_out;
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts start exactly like IDLE for back-to-back use.
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= carry_in;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= {fa_sum, res_sh[WIDTH-1:1]};
          carry_r <= fa_carry;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            // Publish the completed result; res_sh keeps working privately.
            sum       <= {fa_sum, res_sh[WIDTH-1:1]};
            carry_out <= fa_carry;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_add32
`default_nettype wire

// File: doc/serial_add32.md
# serial_add32

Bit-serial ripple adder for the MIPS datapath's multi-cycle arithmetic path. It accepts two WIDTH-bit operands and a carry-in with a start strobe. Each clock it adds one bit pair, LSB first, through a single full-adder cell. It then presents the sum, the carry-out and the signed overflow with a one-cycle done pulse. It is the additive counterpart of the full-subtractor cell and lets area-constrained builds trade latency for a single adder slice.

## Interface
- WIDTH, 32, operand and sum width in bits (must be ≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- carry_in  input  1  initial carry, captured on accepted start
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  a + b + carry_in, modulo 2^WIDTH
- carry_out  output  1  carry out of bit WIDTH-1
- overflow  output  1  two's-complement overflow (see Configuration)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE, start=1:**
  - Load shift registers from a and b.
  - Load the carry register from carry_in.
  - Set the bit counter to 0.
  - Go to SHIFT.
- **IDLE, start=0:** stay in IDLE.
- **SHIFT, each cycle:**
  - Full-adder inputs are the operand LSBs and the carry register.
  - Operands shift right by 1.
  - The sum bit enters the result register at the MSB; the result shifts right.
  - The carry register takes the full-adder carry.
  - The counter increments.
  - When the counter reaches WIDTH-1, go to DONE after that cycle's update.
- **DONE, one cycle:**
  - done=1.
  - start=1 is accepted exactly as in IDLE and goes straight to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- **Result hold:** sum, carry_out and overflow hold their values from DONE until the next DONE. They do not change during a following operation's SHIFT.
  - sum updates only on entry to DONE; the internal result register is separate.
- **start while busy:** ignored. Operands and carry_in changing while busy have no effect.
- **Reset (any state, including mid-operation):**
  - Next state is IDLE.
  - The counter is cleared and the current operation is discarded.
  - Reset has priority over start.
- **Reset values:** busy=0, done=0, sum=0, carry_out=0, overflow=0.
- **Arithmetic:** unsigned ripple. carry_out is the final carry after bit WIDTH-1, with no truncation beyond WIDTH bits.

## Timing
- Start accepted at clock edge k:
  - busy=1 for edges k+1 … k+WIDTH.
  - done=1 and the result is valid after edge k+WIDTH+1.
- Latency: WIDTH+1 cycles from start to done. WIDTH=32 gives 33 cycles.
- Throughput with start held high: one result every WIDTH+1 cycles.
- busy and done are never high together. done is registered, not combinational from start.

## Configuration
- Macro: SERIAL_ADD_OVF_EN.
- **Defined:**
  - One extra flop captures the carry into bit WIDTH-1 during the last SHIFT cycle.
  - overflow = (carry into MSB) XOR carry_out. It is updated on entry to DONE and held with sum.
- **Undefined:** overflow is tied to 0 and the extra flop is not built. All other behaviour is identical.

## Structure
- **Shared package serial_add_pkg:**
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Counter width function clog2(WIDTH).
- **Sub-module add_full** (sum, carry_out, a, b, carry_in):
  - Purely combinational 1-bit full adder.
  - Port order mirrors the existing full-subtractor cell.
  - Instantiated once.
- Remaining top-level logic: FSM, counter, three shift registers, output holding registers.

## Test plan
All values below use WIDTH=32.
- **Reset:** reset=1 for 2 cycles then 0 → busy=0, done=0, sum=0, carry_out=0, overflow=0. State is IDLE and no done pulse follows.
- **Basic add:** a=32'h0000_0005, b=32'h0000_0003, carry_in=0, one-cycle start → busy for 32 cycles. done exactly 33 cycles after start, with sum=32'h0000_0008, carry_out=0, overflow=0.
- **Full wrap:** a=32'hFFFF_FFFF, b=32'h0000_0000, carry_in=1 → sum=0, carry_out=1, overflow=0.
- **Signed overflow:** a=32'h7FFF_FFFF, b=32'h0000_0001, carry_in=0 → sum=32'h8000_0000, carry_out=0, overflow=1 with SERIAL_ADD_OVF_EN and 0 without it.
- **Back-to-back and ignore:**
  - start held high; operands changed while busy → second start is ignored mid-operation.
  - A new operation is accepted in the DONE cycle; the next done follows 33 cycles later.
  - sum holds the first result until then.
- **Reset mid-operation:** reset=1 at SHIFT cycle 10 → next cycle busy=0, state IDLE, no done pulse. The previously held sum is cleared to 0.
